fm_bram_ctrl: RTL

- Sequences one feature-map tile through the true dual-port sync BRAM of the CNN PL datapath: a load phase writes N words from an upstream valid/ready stream via BRAM port 0, then a drain phase reads them back in address order via port 1 to the conv core as a valid/ready stream.
- Sits between the DMA/input-stream adapter and the conv engine; one run = load N, drain N.

---
 rtl/fm_bram_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fm_bram_ctrl.sv
// Feature-map tile sequencer for a true dual-port sync BRAM: a load phase writes N stream words
// through port 0, then a drain phase reads them back in address order through port 1.
module fm_bram_ctrl #(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 10,
  parameter int MEM_SIZE = 650
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_run,
  input  logic [AWIDTH-1:0] i_num_word,
  output logic              o_idle,
  output logic              o_done,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DWIDTH-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data,
  output logic [AWIDTH-1:0] bram_addr0,
  output logic              bram_ce0,
  output logic              bram_we0,
  output logic [DWIDTH-1:0] bram_d0,
  output logic [AWIDTH-1:0] bram_addr1,
  output logic              bram_ce1,
  output logic              bram_we1,
  input  logic [DWIDTH-1:0] bram_q1
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [AWIDTH-1:0] MaxWords = AWIDTH'(MEM_SIZE);
  localparam logic [AWIDTH-1:0] One      = AWIDTH'(1);

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] num_q, num_d;
  logic [AWIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic [AWIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic [AWIDTH-1:0] issue_cnt_q, issue_cnt_d;
  logic              m_valid_q, m_valid_d;
  logic [AWIDTH-1:0] num_clamped;
  logic              out_free;
  logic              issue;

  assign num_clamped = (i_num_word > MaxWords) ? MaxWords : i_num_word;

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    issue_cnt_d = issue_cnt_q;
    m_valid_d   = 1'b0;
    s_ready     = 1'b0;
    o_done      = 1'b0;
    bram_ce0    = 1'b0;
    bram_we0    = 1'b0;
    bram_addr0  = '0;
    bram_d0     = '0;
    bram_ce1    = 1'b0;
    bram_addr1  = '0;
    out_free    = 1'b0;
    issue       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_run) begin
          num_d       = num_clamped;
          wr_cnt_d    = '0;
          rd_cnt_d    = '0;
          issue_cnt_d = '0;
          state_d     = (num_clamped == '0) ? S_DONE : S_LOAD;
        end
      end

      S_LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          bram_ce0   = 1'b1;
          bram_we0   = 1'b1;
          bram_addr0 = wr_cnt_q;
          bram_d0    = s_data;
          wr_cnt_d   = wr_cnt_q + One;
          if (wr_cnt_q == num_q - One) state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        // Only read when the output slot is free, so q1 holds its word through a stall.
        out_free  = !m_valid_q || m_ready;
        issue     = (issue_cnt_q < num_q) && out_free;
        m_valid_d = out_free ? issue : m_valid_q;
        if (issue) begin
          bram_ce1    = 1'b1;
          bram_addr1  = issue_cnt_q;
          issue_cnt_d = issue_cnt_q + One;
        end
        if (m_valid_q && m_ready) begin
          rd_cnt_d = rd_cnt_q + One;
          if (rd_cnt_q == num_q - One) state_d = S_DONE;
        end
      end

      S_DONE: begin
        o_done  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      num_q       <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      issue_cnt_q <= '0;
      m_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      issue_cnt_q <= issue_cnt_d;
      m_valid_q   <= m_valid_d;
    end
  end

  assign o_idle   = (state_q == S_IDLE);
  assign m_valid  = m_valid_q;
  assign m_data   = bram_q1;
  assign bram_we1 = 1'b0;

endmodule
